// File: rtl/rand_stream_arb_pkg.sv
// Shared types and constants for the multiply-with-carry stream arbiter.
package rand_stream_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_SEED
  } arb_state_t;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] w;
  } mwc_state_t;

  localparam logic [31:0] MWC_Z_MULT = 32'd36969;
  localparam logic [31:0] MWC_W_MULT = 32'd18000;
  localparam logic [31:0] MWC_Z_DFLT = 32'd17;
  localparam logic [31:0] MWC_W_DFLT = 32'd3;

  // One MWC half-step: mult * low16 + high16, 32-bit truncated.
  function automatic logic [31:0] mwc_step(input logic [31:0] x, input logic [31:0] mult);
    return mult * {16'h0, x[15:0]} + {16'h0, x[31:16]};
  endfunction

endpackage

// File: rtl/rand_state_ram.sv
// Per-stream {z,w} state store: 2**SBITS x 64 block RAM, one-cycle read via registered address.
// Never stalls; powers up with every entry at the default seeds.
module rand_state_ram
  import rand_stream_arb_pkg::*;
#(
  parameter int          SBITS  = 10,
  parameter logic [31:0] Z_DFLT = MWC_Z_DFLT,
  parameter logic [31:0] W_DFLT = MWC_W_DFLT
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [SBITS-1:0] i_addr,
  input  mwc_state_t       i_wdat,
  output mwc_state_t       o_rdat
);

  (* ram_style = "block" *)
  logic [63:0] r_mem [2**SBITS] = '{default: {Z_DFLT, W_DFLT}};
  logic [SBITS-1:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdat;
    end
    r_addr <= i_addr;
  end

  assign o_rdat = r_mem[r_addr];

endmodule

// File: rtl/rand_stream_arb.sv
// Arbitrates NREQ requesters onto one shared MWC generator; ack 3 cycles after the sampling IDLE cycle, 1 draw / 4 cycles.
// Requesters and seed host hold their level until acked; RAND_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module rand_stream_arb
  import rand_stream_arb_pkg::*;
#(
  parameter int          NREQ   = 4,
  parameter int          SBITS  = 10,
  parameter logic [31:0] Z_DFLT = MWC_Z_DFLT,
  parameter logic [31:0] W_DFLT = MWC_W_DFLT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*SBITS-1:0] stream_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [31:0]           dat_o,
  input  logic                  seed_wr_i,
  input  logic [SBITS-1:0]      seed_stream_i,
  input  logic [31:0]           seed_z_i,
  input  logic [31:0]           seed_w_i,
  output logic                  seed_ack_o,
  output logic                  busy_o
);

  localparam int GW = $clog2(NREQ);

  arb_state_t       r_state, w_state_nxt;
  logic [GW-1:0]    r_grant, w_grant, w_idx;
  logic [SBITS-1:0] r_stream, w_sel_stream;
  logic [31:0]      r_z, r_w, r_nz, r_nw, r_dat;
  logic [31:0]      w_nz, w_nw;
  logic             w_ram_we;
  logic [SBITS-1:0] w_ram_addr;
  mwc_state_t       w_ram_wdat, w_ram_rdat;
`ifdef RAND_ARB_FIXED_PRIO_EN
`else
  logic [GW-1:0]    r_rr_ptr;
`endif

  rand_state_ram #(
    .SBITS  (SBITS),
    .Z_DFLT (Z_DFLT),
    .W_DFLT (W_DFLT)
  ) u_ram (
    .i_clk  (clk_i),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdat (w_ram_wdat),
    .o_rdat (w_ram_rdat)
  );

  // Descending scan so the last hit is the winner: lowest index, or first after rr_ptr.
  always_comb begin
    w_grant      = '0;
    w_idx        = '0;
    w_sel_stream = stream_i[SBITS-1:0];
`ifdef RAND_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = GW'(i);
      if (req_i[w_idx]) w_grant = w_idx;
    end
`else
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = GW'((int'(r_rr_ptr) + i) % NREQ);
      if (req_i[w_idx]) w_grant = w_idx;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant == GW'(k)) w_sel_stream = stream_i[k*SBITS +: SBITS];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (seed_wr_i)   w_state_nxt = S_SEED;
        else if (|req_i) w_state_nxt = S_READ;
      end
      S_READ:  w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      S_SEED:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ram_we     = 1'b0;
    w_ram_addr   = r_stream;
    w_ram_wdat.z = r_nz;
    w_ram_wdat.w = r_nw;
    ack_o        = '0;
    seed_ack_o   = 1'b0;
    busy_o       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  w_ram_addr = w_sel_stream;
      S_WRITE: begin
        w_ram_we = 1'b1;
        ack_o    = NREQ'(1) << r_grant;
      end
      S_SEED: begin
        w_ram_we     = 1'b1;
        w_ram_addr   = seed_stream_i;
        w_ram_wdat.z = (seed_z_i == 32'd0) ? Z_DFLT : seed_z_i;
        w_ram_wdat.w = (seed_w_i == 32'd0) ? W_DFLT : seed_w_i;
        seed_ack_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_nz  = mwc_step(r_z, MWC_Z_MULT);
  assign w_nw  = mwc_step(r_w, MWC_W_MULT);
  assign dat_o = r_dat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant  <= '0;
      r_stream <= '0;
      r_z      <= '0;
      r_w      <= '0;
      r_nz     <= '0;
      r_nw     <= '0;
      r_dat    <= '0;
`ifdef RAND_ARB_FIXED_PRIO_EN
`else
      r_rr_ptr <= GW'(NREQ - 1);
`endif
    end else begin
      if (r_state == S_IDLE && !seed_wr_i && |req_i) begin
        r_grant  <= w_grant;
        r_stream <= w_sel_stream;
`ifdef RAND_ARB_FIXED_PRIO_EN
`else
        r_rr_ptr <= w_grant;
`endif
      end
      if (r_state == S_READ) begin
        r_z <= w_ram_rdat.z;
        r_w <= w_ram_rdat.w;
      end
      if (r_state == S_CALC) begin
        r_nz  <= w_nz;
        r_nw  <= w_nw;
        r_dat <= {w_nz[15:0], 16'h0} + w_nw;
      end
    end
  end

endmodule

// File: tb/tb_rand_stream_arb.sv
// Scoreboard bench for rand_stream_arb: stimulus pushes expected acks/draws, a negedge monitor pops and compares.
module tb_rand_stream_arb;

  localparam int NREQ  = 4;
  localparam int SBITS = 10;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*SBITS-1:0] stream_i;
  logic [NREQ-1:0]       ack_o;
  logic [31:0]           dat_o;
  logic                  seed_wr_i;
  logic [SBITS-1:0]      seed_stream_i;
  logic [31:0]           seed_z_i;
  logic [31:0]           seed_w_i;
  logic                  seed_ack_o;
  logic                  busy_o;

  rand_stream_arb #(.NREQ(NREQ), .SBITS(SBITS)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .stream_i      (stream_i),
    .ack_o         (ack_o),
    .dat_o         (dat_o),
    .seed_wr_i     (seed_wr_i),
    .seed_stream_i (seed_stream_i),
    .seed_z_i      (seed_z_i),
    .seed_w_i      (seed_w_i),
    .seed_ack_o    (seed_ack_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit              is_seed;
    logic [NREQ-1:0] ack;
    logic [31:0]     dat;
    int              cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mdl [int];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference MWC model over streams; untouched streams hold the power-up defaults.
  function automatic logic [31:0] mdl_draw(input int s);
    logic [63:0] st;
    logic [31:0] z, w;
    st = mdl.exists(s) ? mdl[s] : {32'd17, 32'd3};
    z = 32'd36969 * {16'h0, st[47:32]} + {16'h0, st[63:48]};
    w = 32'd18000 * {16'h0, st[15:0]} + {16'h0, st[31:16]};
    mdl[s] = {z, w};
    return {z[15:0], 16'h0} + w;
  endfunction

  task automatic push_draw(input int r, input logic [31:0] d, input int c);
    exp_t e;
    e.is_seed = 1'b0;
    e.ack     = NREQ'(1) << r;
    e.dat     = d;
    e.cyc     = c;
    sbq.push_back(e);
  endtask

  task automatic push_seed();
    exp_t e;
    e.is_seed = 1'b1;
    e.ack     = '0;
    e.dat     = '0;
    e.cyc     = -1;
    sbq.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && (|ack_o || seed_ack_o)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: ack=%b seed_ack=%b with no expectation", ack_o, seed_ack_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_kind", 64'(seed_ack_o), 64'(e.is_seed));
        chk("ack_vec", 64'(ack_o), 64'(e.ack));
        if (!e.is_seed) chk("dat", 64'(dat_o), 64'(e.dat));
        if (e.cyc >= 0) chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Returns just after the negedge on which the awaited pulse is visible.
  task automatic wait_sig(input bit want_seed, input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      #1;
      if (want_seed ? seed_ack_o : |ack_o) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout after %0d cycles", name, maxc);
  endtask

  task automatic set_stream(input int k, input int s);
    stream_i[k*SBITS +: SBITS] = SBITS'(s);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int c0;
    rst_i = 1'b1; req_i = '0; stream_i = '0;
    seed_wr_i = 1'b0; seed_stream_i = '0; seed_z_i = '0; seed_w_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", 64'(ack_o), 64'(0));
    chk("rst_dat", 64'(dat_o), 64'(0));
    chk("rst_seed_ack", 64'(seed_ack_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    rst_i = 1'b0;

    // First draw on stream 0 from power-up defaults.
    tick();
    req_i = 4'b0001; set_stream(0, 0);
    push_draw(0, 32'h96F9D2F0, cyc + 3);
    void'(mdl_draw(0));
    wait_sig(1'b0, 8, "t1_ack");
    chk("t1_busy", 64'(busy_o), 64'(1));
    req_i = '0;

    // Zero seeds are replaced by the defaults.
    tick();
    seed_wr_i = 1'b1; seed_stream_i = 10'd5; seed_z_i = 32'd0; seed_w_i = 32'd0;
    push_seed();
    mdl[5] = {32'd17, 32'd3};
    wait_sig(1'b1, 8, "t2_seed_ack");
    seed_wr_i = 1'b0;
    tick();
    req_i = 4'b0001; set_stream(0, 5);
    push_draw(0, 32'h96F9D2F0, -1);
    void'(mdl_draw(5));
    wait_sig(1'b0, 8, "t2_ack");
    req_i = '0;

    // All four held: service order from reset and 4-cycle spacing.
    do_reset();
    tick();
    for (int k = 0; k < NREQ; k++) set_stream(k, 10 + k);
    req_i = 4'b1111;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
`ifdef RAND_ARB_FIXED_PRIO_EN
      push_draw(0, mdl_draw(10), c0 + 3 + 4 * k);
`else
      push_draw(k % NREQ, mdl_draw(10 + (k % NREQ)), c0 + 3 + 4 * k);
`endif
    end
    for (int k = 0; k < 5; k++) wait_sig(1'b0, 10, "t3_ack");
    req_i = '0;

    // Seed and request in the same IDLE cycle: seed first, draw uses new seed.
    tick();
    seed_wr_i = 1'b1; seed_stream_i = 10'd7; seed_z_i = 32'd1234; seed_w_i = 32'd5678;
    req_i = 4'b0100; set_stream(2, 7);
    push_seed();
    mdl[7] = {32'd1234, 32'd5678};
    push_draw(2, 32'h20398260, -1);
    void'(mdl_draw(7));
    wait_sig(1'b1, 8, "t4_seed_ack");
    seed_wr_i = 1'b0;
    wait_sig(1'b0, 8, "t4_ack");
    req_i = '0;

    // Reset during CALC: outputs clear at once, RAM entry untouched.
    tick();
    req_i = 4'b0001; set_stream(0, 7);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    chk("t5_busy_calc", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk("t5_rst_ack", 64'(ack_o), 64'(0));
    chk("t5_rst_dat", 64'(dat_o), 64'(0));
    chk("t5_rst_seed_ack", 64'(seed_ack_o), 64'(0));
    chk("t5_rst_busy", 64'(busy_o), 64'(0));
    req_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    req_i = 4'b0001;
    push_draw(0, mdl_draw(7), cyc + 3);
    wait_sig(1'b0, 8, "t5_ack");
    req_i = '0;

`ifdef RAND_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 always beats requester 3.
    tick();
    set_stream(1, 30); set_stream(3, 31);
    req_i = 4'b1010;
    for (int k = 0; k < 3; k++) push_draw(1, mdl_draw(30), -1);
    for (int k = 0; k < 3; k++) wait_sig(1'b0, 10, "t6_ack");
    req_i = '0;
`endif

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    repeat (6) tick();
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
